leaf_out_packetizer: RTL and testbench

Converts the user kernel's per-port 32-bit output streams into 49-bit BFT packets for the leaf. It sits between the user kernel's `din_leaf_user2interface_*`/`vld_user2interface_*`/`ack_interface2user_*` ports and the BFT-facing `dout_leaf_interface2bft` path, on the interface clock domain. It provides:
- per-output-port destination routing
- a 7-bit write-address (sequence) field per port
- round-robin arbitration between ports
- credit-based flow control against the receiving leaf's BRAM free space

---
 rtl/leaf_out_packetizer_pkg.sv | 36 +++
 rtl/leaf_out_packetizer_rr_arbiter.sv | 37 +++
 rtl/leaf_out_packetizer.sv | 177 +++++++++++++++++
 tb/tb_leaf_out_packetizer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_out_packetizer_pkg.sv
// ============================================================================
// Module   : leaf_pkt_pkg
// Brief    : Packet field layout, route-table entry type and credit constants
//            shared by the leaf output packetizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package leaf_pkt_pkg;

    localparam int VALID_BIT   = 48;
    localparam int LEAF_MSB    = 47;
    localparam int LEAF_LSB    = 43;
    localparam int PORT_MSB    = 42;
    localparam int PORT_LSB    = 39;
    localparam int ADDR_MSB    = 38;
    localparam int ADDR_LSB    = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    localparam int LEAF_BITS = LEAF_MSB - LEAF_LSB + 1;
    localparam int PORT_BITS = PORT_MSB - PORT_LSB + 1;
    localparam int DEST_BITS = LEAF_BITS + PORT_BITS;

    // dest is {leaf, port}, matching the cfg_dest layout
    typedef struct packed {
        logic [DEST_BITS-1:0] dest;
        logic                 configured;
    } route_entry_t;

    localparam int               CREDIT_BITS  = 8;
    localparam logic [CREDIT_BITS-1:0] CREDIT_RESET = 8'd128;

endpackage

`default_nettype wire

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; one-hot pointer marks the highest-priority
//            request, pointer advances past the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [NUM_REQ-1:0] o_ptr_next,
    output logic               o_grant_any
);

    localparam logic [NUM_REQ-1:0] c_one = NUM_REQ'(1);

    logic [NUM_REQ-1:0] w_masked;

    always_comb begin
        // requests at or above the pointer win first, otherwise wrap around
        w_masked = i_req & ~(i_ptr - c_one);
        if (|w_masked) begin
            o_grant = w_masked & (~w_masked + c_one);
        end else begin
            o_grant = i_req & (~i_req + c_one);
        end
        o_grant_any = |i_req;
        o_ptr_next  = o_grant_any ? {o_grant[NUM_REQ-2:0], o_grant[NUM_REQ-1]} : i_ptr;
    end

endmodule

`default_nettype wire

// File: rtl/leaf_out_packetizer.sv
// ============================================================================
// Module   : leaf_out_packetizer
// Brief    : Packs per-port user output words into BFT packets with routing,
//            sequence addressing, round-robin arbitration and credits.
// Options  : PACKETIZER_CREDIT_EN - per-port receiver credit flow control
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leaf_out_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 4,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_vld,
    input  logic [1:0]                              cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    credit_vld,
    input  logic [1:0]                              credit_port,
    input  logic                                    resend,
    input  logic                                    out_ready,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

    localparam int                       c_credit_w   = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [c_credit_w-1:0]    c_credit_max = c_credit_w'(CREDIT_RESET);
    localparam logic [c_credit_w:0]      c_credit_inc = (c_credit_w + 1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [NUM_OUT_PORTS-1:0] c_ptr_reset  = NUM_OUT_PORTS'(1);
    localparam logic [NUM_ADDR_BITS-1:0] c_seq_one    = NUM_ADDR_BITS'(1);

    logic [NUM_OUT_PORTS-1:0] r_full;
    logic [PAYLOAD_BITS-1:0]  r_payload [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] r_seq     [NUM_OUT_PORTS];
    route_entry_t             r_route   [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] r_ptr;
    logic [PACKET_BITS-1:0]   r_out_pkt;

    logic [NUM_OUT_PORTS-1:0] w_cfgd;
    logic [NUM_OUT_PORTS-1:0] w_credit_ok;
    logic [NUM_OUT_PORTS-1:0] w_req;
    logic [NUM_OUT_PORTS-1:0] w_grant;
    logic [NUM_OUT_PORTS-1:0] w_ptr_next;
    logic                     w_grant_any;
    logic                     w_can_issue;
    logic [PACKET_BITS-1:0]   w_sel_pkt;

    assign ack_interface2user = ~r_full;

    // a new packet may enter only if the output slot is empty or draining now
    assign w_can_issue = !resend && (!r_out_pkt[VALID_BIT] || out_ready);

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_cfgd[i] = r_route[i].configured;
        end
        w_req = r_full & w_cfgd & w_credit_ok & {NUM_OUT_PORTS{w_can_issue}};
    end

    rr_arbiter #(
        .NUM_REQ (NUM_OUT_PORTS)
    ) u_arb (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_ptr_next  (w_ptr_next),
        .o_grant_any (w_grant_any)
    );

    always_comb begin
        w_sel_pkt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (w_grant[i]) begin
                w_sel_pkt[VALID_BIT]               = 1'b1;
                w_sel_pkt[LEAF_MSB:LEAF_LSB]       = r_route[i].dest[DEST_BITS-1:PORT_BITS];
                w_sel_pkt[PORT_MSB:PORT_LSB]       = r_route[i].dest[PORT_BITS-1:0];
                w_sel_pkt[ADDR_MSB:ADDR_LSB]       = r_seq[i];
                w_sel_pkt[PAYLOAD_MSB:PAYLOAD_LSB] = r_payload[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= '0;
            r_ptr  <= c_ptr_reset;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_payload[i] <= '0;
                r_seq[i]     <= '0;
                r_route[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                // fill and grant are exclusive: a grant requires the slot full
                if (vld_user2interface[i] && !r_full[i]) begin
                    r_full[i]    <= 1'b1;
                    r_payload[i] <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
                if (w_grant[i]) begin
                    r_seq[i] <= r_seq[i] + c_seq_one;
                end
                if (cfg_vld && (cfg_port == 2'(i))) begin
                    r_route[i].dest       <= cfg_dest;
                    r_route[i].configured <= 1'b1;
                end
            end
            if (w_grant_any) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // output slot: resend freezes it so the same packet is presented again
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_pkt <= '0;
        end else if (w_grant_any) begin
            r_out_pkt <= w_sel_pkt;
        end else if (!resend && out_ready) begin
            r_out_pkt <= '0;
        end
    end

    assign dout_leaf_interface2bft = resend ? '0 : r_out_pkt;

`ifdef PACKETIZER_CREDIT_EN
    localparam logic [c_credit_w:0] c_sum_one = (c_credit_w + 1)'(1);

    logic [c_credit_w-1:0] r_credit      [NUM_OUT_PORTS];
    logic [c_credit_w:0]   w_credit_sum  [NUM_OUT_PORTS];
    logic [c_credit_w-1:0] w_credit_next [NUM_OUT_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_credit_sum[i] = {1'b0, r_credit[i]}
                            + ((credit_vld && (credit_port == 2'(i))) ? c_credit_inc : '0)
                            - (w_grant[i] ? c_sum_one : '0);
            w_credit_next[i] = (w_credit_sum[i] > {1'b0, c_credit_max})
                             ? c_credit_max : w_credit_sum[i][c_credit_w-1:0];
            w_credit_ok[i]   = (r_credit[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_credit[i] <= c_credit_max;
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_credit[i] <= w_credit_next[i];
            end
        end
    end
`else
    logic w_unused_credit;

    assign w_credit_ok     = '1;
    assign w_unused_credit = ^{credit_vld, credit_port, c_credit_max, c_credit_inc};
`endif

endmodule

`default_nettype wire

// File: tb/tb_leaf_out_packetizer.sv
// ============================================================================
// Module   : tb_leaf_out_packetizer
// Brief    : Self-checking bench for leaf_out_packetizer with a cycle-level
//            behavioural model plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leaf_out_packetizer;

`ifdef PACKETIZER_CREDIT_EN
    localparam bit CREDIT_EN = 1'b1;
`else
    localparam bit CREDIT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] din = '0;
    logic [3:0]   vld = '0;
    logic [3:0]   ack;
    logic         cfg_vld = 1'b0;
    logic [1:0]   cfg_port = '0;
    logic [8:0]   cfg_dest = '0;
    logic         credit_vld = 1'b0;
    logic [1:0]   credit_port = '0;
    logic         resend = 1'b0;
    logic         out_ready = 1'b1;
    logic [48:0]  dout;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;
    int emit_total = 0;

    always #5 clk = ~clk;

    leaf_out_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_vld                 (cfg_vld),
        .cfg_port                (cfg_port),
        .cfg_dest                (cfg_dest),
        .credit_vld              (credit_vld),
        .credit_port             (credit_port),
        .resend                  (resend),
        .out_ready               (out_ready),
        .dout_leaf_interface2bft (dout)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_pay   [4];
    bit          m_full  [4];
    bit          m_cfg   [4];
    logic [8:0]  m_dest  [4];
    int          m_seq   [4];
    int          m_credit[4];
    int          m_last = 3;
    bit          m_valid = 1'b0;
    logic [48:0] m_out = '0;
    bit   [3:0]  m_xfer = '0;
    bit   [3:0]  m_xf;
    int          m_g;

    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                m_full[p] = 1'b0; m_cfg[p] = 1'b0; m_dest[p] = '0;
                m_seq[p] = 0; m_credit[p] = 128; m_pay[p] = '0;
            end
            m_last = 3; m_valid = 1'b0; m_out = '0; m_xf = '0;
        end else begin
            for (int p = 0; p < 4; p++) m_xf[p] = vld[p] && !m_full[p];
            m_g = -1;
            if (!resend && (!m_valid || out_ready)) begin
                for (int k = 1; k <= 4; k++) begin
                    int p;
                    p = (m_last + k) % 4;
                    if (m_g < 0 && m_full[p] && m_cfg[p] && (!CREDIT_EN || m_credit[p] > 0)) m_g = p;
                end
            end
            if (m_g >= 0) begin
                m_out = {1'b1, m_dest[m_g], 7'(m_seq[m_g]), m_pay[m_g]};
                m_valid = 1'b1;
                m_seq[m_g] = (m_seq[m_g] + 1) % 128;
                m_credit[m_g] = m_credit[m_g] - 1;
                m_full[m_g] = 1'b0;
                m_last = m_g;
            end else if (!resend && out_ready && m_valid) begin
                m_valid = 1'b0;
            end
            if (credit_vld)
                m_credit[credit_port] = (m_credit[credit_port] + 64 > 128) ? 128 : m_credit[credit_port] + 64;
            for (int p = 0; p < 4; p++) begin
                if (m_xf[p]) begin
                    m_full[p] = 1'b1;
                    m_pay[p]  = din[p*32 +: 32];
                end
            end
            if (cfg_vld) begin
                m_cfg[cfg_port]  = 1'b1;
                m_dest[cfg_port] = cfg_dest;
            end
        end
        m_xfer = m_xf;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [48:0] exp_dout;
        logic [3:0]  exp_ack;
        if (chk_en) begin
            exp_dout = (m_valid && !resend) ? m_out : '0;
            for (int p = 0; p < 4; p++) exp_ack[p] = !m_full[p];
            n_checks++;
            if (dout !== exp_dout) begin
                n_err++;
                if (n_err < 30) $display("FAIL model_dout t=%0t got=%h exp=%h", $time, dout, exp_dout);
            end
            n_checks++;
            if (ack !== exp_ack) begin
                n_err++;
                if (n_err < 30) $display("FAIL model_ack t=%0t got=%b exp=%b", $time, ack, exp_ack);
            end
        end
        if (dout[48] && out_ready) emit_total++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) if (m_xfer[p]) din[p*32 +: 32] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, base, prev, c;
        bit got;

        // reset state
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ack", 64'(ack), 64'hF);
        check("reset_dout", 64'(dout), 64'h0);
        reset = 1'b0;

        // single word on port 1 -> leaf 3 / port 2
        tick();
        cfg_vld = 1'b1; cfg_port = 2'd0; cfg_dest = {5'd3, 4'd2};
        tick();
        cfg_vld = 1'b0; vld = 4'b0001; din[31:0] = 32'hDEADBEEF;
        tick();
        vld = 4'b0000;
        tick();
        @(negedge clk);
        check("first_packet", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        vld = 4'b0001; din[31:0] = 32'h12345678;
        tick();
        vld = 4'b0000;
        tick();
        @(negedge clk);
        check("second_addr", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd1, 32'h12345678}));

        // all four ports streaming: strict rotation, one packet per cycle
        for (int p = 0; p < 4; p++) begin
            tick();
            cfg_vld = 1'b1; cfg_port = 2'(p); cfg_dest = {5'd1, 4'(p)};
        end
        tick();
        cfg_vld = 1'b0; vld = 4'b1111;
        repeat (12) tick();
        @(negedge clk);
        check("rr_valid0", 64'(dout[48]), 64'h1);
        prev = int'(dout[42:39]);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("rr_valid", 64'(dout[48]), 64'h1);
            check("rr_order", 64'(dout[42:39]), 64'((prev + 1) % 4));
            prev = int'(dout[42:39]);
        end

        // reset with holding registers full
        #1;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; vld = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 64'(ack), 64'hF);
        check("rst_mid_dout", 64'(dout), 64'h0);

        // credit exhaustion on port 1
        tick();
        cfg_vld = 1'b1; cfg_port = 2'd0; cfg_dest = {5'd3, 4'd0};
        tick();
        cfg_vld = 1'b0;
        base = emit_total; cnt = 0;
        vld = 4'b0001;
        for (c = 0; c < 400 && cnt < 130; c++) begin
            tick();
            if (m_xfer[0]) cnt++;
        end
        vld = 4'b0000;
        repeat (5) tick();
        check("credit_emitted", 64'(emit_total - base), CREDIT_EN ? 64'd128 : 64'd130);
        check("credit_ack", 64'(ack[0]), CREDIT_EN ? 64'd0 : 64'd1);
        credit_vld = 1'b1; credit_port = 2'd0;
        tick();
        credit_vld = 1'b0;
        for (c = 0; c < 60 && cnt < 130; c++) begin
            vld = 4'b0001;
            tick();
            if (m_xfer[0]) cnt++;
        end
        vld = 4'b0000;
        repeat (10) tick();
        check("credit_words", 64'(cnt), 64'd130);
        check("credit_total", 64'(emit_total - base), 64'd130);
        check("credit_ack_back", 64'(ack[0]), 64'd1);

        // unconfigured port 2 holds its word until configured
        base = emit_total;
        vld = 4'b0010; din[63:32] = 32'hCAFE0002;
        tick();
        vld = 4'b0000;
        repeat (8) tick();
        check("unconf_ack", 64'(ack[1]), 64'd0);
        check("unconf_none", 64'(emit_total - base), 64'd0);
        cfg_vld = 1'b1; cfg_port = 2'd1; cfg_dest = {5'd7, 4'd1};
        tick();
        cfg_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("unconf_emit", 64'(dout), 64'({1'b1, 5'd7, 4'd1, 7'd0, 32'hCAFE0002}));

        // resend mid-stream
        #1;
        vld = 4'b0010;
        repeat (6) tick();
        got = 1'b0; prev = 0;
        for (c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (dout[48]) begin got = 1'b1; prev = int'(dout[38:32]); end
        end
        check("resend_pre", 64'(got), 64'd1);
        tick();
        resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("resend_mask", 64'(dout), 64'h0);
            tick();
        end
        resend = 1'b0;
        got = 1'b0;
        for (c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (dout[48]) begin
                got = 1'b1;
                check("resend_seq", 64'(dout[38:32]), 64'((prev + 1) % 128));
            end
        end
        check("resend_post", 64'(got), 64'd1);
        #1;
        vld = 4'b0000;

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            vld         = 4'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            resend      = ($urandom_range(0, 9) == 0);
            cfg_vld     = ($urandom_range(0, 19) == 0);
            cfg_port    = 2'($urandom);
            cfg_dest    = 9'($urandom);
            credit_vld  = ($urandom_range(0, 24) == 0);
            credit_port = 2'($urandom);
            reset       = ($urandom_range(0, 255) == 0);
            din         = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        vld = '0; resend = 1'b0; cfg_vld = 1'b0; credit_vld = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
